// File: rtl/mu0_pkg.sv
// Shared MU0 datapath definitions: word width, word type and mux select encodings.
package mu0_pkg;

  localparam int unsigned MU0_WORD_W = 16;

  typedef logic [MU0_WORD_W-1:0] mu0_word_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : mu0_pkg

// File: rtl/mu0_mux_bit.sv
// Single-bit 2:1 mux; the ternary keeps X-merge behaviour when the select is unknown.
module mu0_mux_bit
  import mu0_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic s,
  output logic q
);

  // Equal a/b bits pass through even if s is X, others go X.
  assign q = (s == SEL_B) ? b : a;

endmodule : mu0_mux_bit

// File: rtl/mu0_mux16.sv
// MU0 16-bit 2:1 word mux with a zero-latency output and a registered status copy.
module mu0_mux16
  import mu0_pkg::*;
#(
  parameter int unsigned WIDTH = MU0_WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             S,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_r,
  output logic             S_r,
  output logic             S_chg
);

  // Bitwise mux slices; Q is independent of clk and reset.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mu0_mux_bit u_bit (
      .a (A[i]),
      .b (B[i]),
      .s (S),
      .q (Q[i])
    );
  end

  // Status register: delayed copy of Q and S, plus a select-change pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      Q_r   <= '0;
      S_r   <= 1'b0;
      S_chg <= 1'b0;
    end else begin
      Q_r   <= Q;
      S_r   <= S;
      S_chg <= (S != S_r);
    end
  end

endmodule : mu0_mux16

// File: tb/tb_mu0_mux16.sv
// Directed self-checking bench for mu0_mux16 with a scoreboard for registered outputs.
module tb_mu0_mux16;

  logic        clk;
  logic        reset;
  logic [15:0] A;
  logic [15:0] B;
  logic        S;
  logic [15:0] Q;
  logic [15:0] Q_r;
  logic        S_r;
  logic        S_chg;

  typedef struct packed {
    logic [15:0] qr;
    logic        sr;
    logic        schg;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic        m_sr  = 1'b0;

  mu0_mux16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .S     (S),
    .Q     (Q),
    .Q_r   (Q_r),
    .S_r   (S_r),
    .S_chg (S_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one vector at negedge, check Q at once, then check registers after the edge.
  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic rst, input string tag);
    exp_t e;
    exp_t got;
    logic [15:0] q_exp;
    @(negedge clk);
    A = a; B = b; S = s; reset = rst;
    q_exp = s ? b : a;
    #1;
    check({tag, ".Q"}, Q, q_exp);
    if (rst) begin
      e = '0;
      m_sr = 1'b0;
    end else begin
      e.qr = q_exp;
      e.sr = s;
      e.schg = (s != m_sr);
      m_sr = s;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      got = sb_q.pop_front();
      check({tag, ".Q_r"}, Q_r, got.qr);
      check({tag, ".S_r"}, {15'd0, S_r}, {15'd0, got.sr});
      check({tag, ".S_chg"}, {15'd0, S_chg}, {15'd0, got.schg});
    end
  endtask

  initial begin
    reset = 1'b1; A = '0; B = '0; S = 1'b0;
    step(16'h0000, 16'h0000, 1'b0, 1'b1, "reset0");
    step(16'h1000, 16'h0001, 1'b0, 1'b0, "selA");
    step(16'h1000, 16'h0001, 1'b1, 1'b0, "selB");
    step(16'h1110, 16'h0011, 1'b0, 1'b0, "backA");
    step(16'h1110, 16'h0111, 1'b1, 1'b0, "holdB1");
    step(16'h1110, 16'h0111, 1'b1, 1'b0, "holdB2");
    // Mid-stream reset while S was 1; Q stays combinational.
    step(16'hFFFF, 16'h0000, 1'b0, 1'b1, "rstMid");
    step(16'hFFFF, 16'h0000, 1'b0, 1'b0, "rstRel");
    step(16'hA5A5, 16'h5A5A, 1'b1, 1'b1, "rstSel1");
    step(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, "relSel1");
    for (int k = 0; k < 16; k++) begin
      logic [15:0] w;
      w = 16'h0001 << k;
      step(w, 16'h0000, 1'b0, 1'b0, $sformatf("walkA%0d", k));
      step(w, 16'h0000, 1'b1, 1'b0, $sformatf("walkAs1_%0d", k));
      step(16'h0000, w, 1'b1, 1'b0, $sformatf("walkB%0d", k));
      step(16'h0000, w, 1'b0, 1'b0, $sformatf("walkBs0_%0d", k));
      step(w, ~w, 1'b1, 1'b0, $sformatf("walkInv%0d", k));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mu0_mux16
